// File: rtl/fifo_byte_packer_pkg.sv
// Shared constants and FIFO payload type for the byte packer.
// The payload struct fixes the FIFO width as data plus the frame-end bit.
package fifo_byte_packer_pkg;

  localparam int BYTE_W = 8;
  localparam int KL_DEF = 2;
  localparam logic [BYTE_W-1:0] PAD_DEF = 8'h00;
  localparam int CNT_W = 16;
  localparam int WORD_W = BYTE_W << KL_DEF;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_word_t;

  localparam int FIFO_NB = $bits(fifo_word_t);

endpackage

// File: rtl/fifo_byte_packer_outreg.sv
// Single-entry output holding register feeding the FIFO write port.
// Holds data stable until out_ready; reloads in the transfer cycle.
module fifo_byte_packer_outreg
  import fifo_byte_packer_pkg::*;
#(
  parameter int Nb = 32
) (
  input  logic             wr_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Nb-1:0]    load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             slot_free,
  output logic             out_valid,
  output logic [Nb-1:0]    out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      word_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_byte_packer.sv
// Packs a byte stream into K-byte words for the async FIFO write port.
// Frame ends and flushes emit a PAD-filled partial word.
module fifo_byte_packer
  import fifo_byte_packer_pkg::*;
#(
  parameter int              NbIn       = BYTE_W,
  parameter int              KL         = KL_DEF,
  parameter int              NbOut      = NbIn << KL,
  parameter logic [NbIn-1:0] PAD        = PAD_DEF,
  parameter bit              BIG_ENDIAN = 1'b0
) (
  input  logic             wr_clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [NbIn-1:0]  in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [NbOut-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
);

  localparam int K = 1 << KL;

  typedef enum logic {
    ST_FILL,
    ST_HOLD
  } st_t;

  st_t state, state_nx;

  logic [K-1:0][NbIn-1:0] acc, acc_wr;
  logic [KL-1:0]          idx, lane;
  logic                   acc_last;
  logic                   accept, done_byte, done_flush;
  logic                   complete, comp_last;
  logic                   slot_free, load, load_last;
  logic [NbOut-1:0]       load_data;

  assign in_ready = (state == ST_FILL);

  // Mirrored lane for big-endian is simply the bitwise inverse of idx
  always_comb begin
    lane       = BIG_ENDIAN ? ~idx : idx;
    accept     = in_valid && in_ready;
    acc_wr     = acc;
    if (accept)
      acc_wr[lane] = in_data;
    done_byte  = accept && (&idx || in_last);
    done_flush = flush && in_ready && (|idx || accept);
    complete   = done_byte || done_flush;
    comp_last  = accept && in_last;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    load_data = acc_wr;
    load_last = comp_last;
    unique case (state)
      ST_FILL: begin
        if (complete) begin
          if (slot_free) load = 1'b1;
          else           state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        load_data = acc;
        load_last = acc_last;
        if (slot_free) begin
          load     = 1'b1;
          state_nx = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) state <= ST_FILL;
    else       state <= state_nx;
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      acc      <= {K{PAD}};
      idx      <= '0;
      acc_last <= 1'b0;
    end else if (complete) begin
      idx      <= '0;
      acc_last <= comp_last;
      acc      <= slot_free ? {K{PAD}} : acc_wr;
    end else if (accept) begin
      idx <= idx + 1'b1;
      acc <= acc_wr;
    end else if (state == ST_HOLD && slot_free) begin
      acc <= {K{PAD}};
    end
  end

  fifo_byte_packer_outreg #(
    .Nb(NbOut)
  ) u_outreg (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_count(word_count)
  );

endmodule

// File: doc/fifo_byte_packer.md
Name: fifo_byte_packer

Overview:
Write-side feeder for the async FIFO. Accepts an 8-bit byte stream from the host interface, packs K bytes into one wide word and presents it to the FIFO write port with a valid/ready handshake. Short frames (in_last) or a flush request emit a padded partial word. The block runs entirely in the FIFO's wr_clk domain, so out_ready connects directly to the FIFO's wr_ready.

Parameters:
NbIn, 8, input byte width
KL, 2, log2 of bytes per word; K = 1<<KL (K >= 2)
NbOut, NbIn<<KL, output word width (derived; do not override)
PAD, 8'h00, fill value for unfilled byte lanes
BIG_ENDIAN, 0, 0: first byte in lane 0 (LSBs); 1: first byte in lane K-1 (MSBs)

Ports:
wr_clk  in  1  clock (FIFO write clock)
reset  in  1  sync active-high reset
in_valid  in  1  byte available
in_data  in  NbIn  byte
in_last  in  1  byte is final of frame
in_ready  out  1  byte accepted when in_valid && in_ready
flush  in  1  single-cycle pulse; emit partial word now
out_valid  out  1  word available to FIFO
out_data  out  NbOut  packed word
out_last  out  1  word closes a frame (store as FIFO extra bit)
out_ready  in  1  FIFO wr_ready
word_count  out  16  words transferred since reset, wraps

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is wr_clk. All outputs are registered.
- State:
  - acc: K byte lanes
  - idx[KL-1:0]: next lane to fill
  - acc_done: completed word waiting for the output slot
  - acc_last
  - out register: out_data, out_last, out_valid
- Reset values: out_valid=0, out_data=0, out_last=0, word_count=0, idx=0, acc_done=0, acc lanes=PAD. in_ready=1 from the first cycle after reset. A reset mid-frame discards the partial word and any pending word.
- in_ready = !acc_done (combinational from a register; no dependence on in_valid).
- Byte accept (in_valid && in_ready):
  - Write acc lane idx (mirrored when BIG_ENDIAN), idx <= idx+1.
  - The word completes when idx==K-1 or in_last=1. acc_last = in_last.
- Flush completes the accumulator when idx>0 or a byte is accepted in the same cycle, with acc_last=0.
  - Flush with nothing accumulated is a no-op.
  - Flush while acc_done=1 is ignored.
- Output slot is free when !out_valid || out_ready.
- On completion:
  - Slot free: the word loads the out register directly; out_valid=1 next cycle (1-cycle latency from final byte). idx returns to 0 and lanes reset to PAD.
  - Slot busy: set acc_done (in_ready drops next cycle).
  - While acc_done=1, the word moves to the out register on the first cycle the slot is free. acc_done clears in that cycle, and in_ready=1 the following cycle.
- Unfilled lanes of a partial word carry PAD.
- out_valid is held with data stable until out_ready. It falls the cycle after the transfer unless a new word loads in the same cycle (back-to-back allowed).
- Throughput: with out_ready held at 1, one byte per cycle with no stalls (K>=2).
- word_count increments on out_valid && out_ready, modulo 2^16.
- Simultaneous acc_done drain and byte accept cannot occur (in_ready=0 while acc_done=1).

Decomposition:
- Shared package:
  - byte width constant (8)
  - default KL
  - PAD default
  - typedef for the {last, data} FIFO payload so the packer output and the FIFO Nb agree (Nb = NbOut+1)
- One natural sub-module: fifo_byte_packer_outreg, the single-entry output holding register with valid/ready and load/hold logic.
- Lane steering and the FSM stay in the top module.

Test Plan:
- Streaming: K=4, out_ready=1, bytes 01..08 back-to-back, no in_last → out_data 32'h04030201 then 32'h08070605, each out_valid 1 cycle after its 4th byte, in_ready constantly 1, word_count=2.
- Partial frame: bytes AA,BB with in_last on BB, PAD=00 → out_data 32'h0000BBAA, out_last=1. The next byte lands in lane 0.
- Backpressure: out_ready=0 while 8 bytes are offered → first word held stable in out_valid. in_ready drops after the 8th byte is accepted (acc_done). Raising out_ready drains both words in consecutive cycles with no data loss.
- Flush: 3 bytes 11,22,33 then flush pulse → 32'h00332211 with out_last=0. A second flush with idx=0 produces no word.
- BIG_ENDIAN=1: bytes 01..04 → 32'h01020304.
- Reset mid-frame after 2 bytes, with a word pending under out_ready=0 → out_valid=0 and word_count=0 next cycle. The next 4 bytes produce exactly one clean word.
